dt_sti_loader: RTL and testbench

Front-end stage of the distance-transform datapath. It streams the 1024×16-bit packed binary image out of the source-image ROM, unpacks each word into 16 one-byte pixels, and writes them into the 16384-byte result RAM at their row-major addresses. The forward and backward passes then run in place on that RAM. It is a single-clock engine with a start/done handshake, one ROM word prefetch, and exactly one RAM write per cycle while streaming.

---
 rtl/dt_sti_loader.sv | 149 ++++++++++++++
 tb/tb_dt_sti_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_sti_loader.sv
// dt_sti_loader
// Front end of the distance-transform datapath. Streams the packed binary
// source image out of the ROM one 16-bit word at a time, unpacks each word
// MSB-first into 16 one-byte pixels and writes them to the result RAM at
// their row-major addresses, one pixel per cycle with no bubbles between
// words (the next word is fetched while pixel 15 of the current one is
// presented).
//
// Parameters:
//   N_WORDS   number of ROM words to unpack (1..1024)
//   SKIP_ZERO when 1, only pixels equal to 1 are written (RAM pre-cleared)
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     run request, sampled only in IDLE
//   busy      high from the cycle after start through the last pixel
//   done      one-cycle pulse after the last pixel
//   sti_rd    ROM read enable
//   sti_addr  ROM word address
//   sti_di    ROM data (updated by the ROM on the falling edge)
//   res_wr    RAM write enable
//   res_addr  RAM pixel address {word, pixel index}
//   res_do    RAM write data {7'b0, pixel}
module dt_sti_loader #(
  parameter int N_WORDS   = 1024,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        sti_rd,
  output logic [9:0]  sti_addr,
  input  logic [15:0] sti_di,
  output logic        res_wr,
  output logic [13:0] res_addr,
  output logic [7:0]  res_do
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [9:0] LAST_W = 10'(N_WORDS - 1);

  state_t      state;
  logic [9:0]  w_cnt;
  logic [3:0]  k_cnt;
  logic [15:0] pix_sr;

  // Write enable for a presented pixel: zero pixels are skipped when the
  // RAM is known to be pre-cleared.
  function automatic logic pix_wr_en(input logic pix);
    return SKIP_ZERO ? pix : 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sti_rd   <= 1'b0;
      sti_addr <= '0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
      w_cnt    <= '0;
      k_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            busy     <= 1'b1;
            sti_rd   <= 1'b1;
            sti_addr <= '0;
            w_cnt    <= '0;
            k_cnt    <= '0;
          end
        end

        // Word 0 arrives: present its leftmost pixel straight from the ROM
        // bus and keep the remaining 15 bits in the shift register.
        S_FETCH: begin
          state    <= S_WRITE;
          sti_rd   <= 1'b0;
          pix_sr   <= {sti_di[14:0], 1'b0};
          k_cnt    <= '0;
          res_addr <= {w_cnt, 4'd0};
          res_do   <= {7'b0, sti_di[15]};
          res_wr   <= pix_wr_en(sti_di[15]);
        end

        S_WRITE: begin
          if (k_cnt == 4'd15) begin
            if (w_cnt == LAST_W) begin
              state    <= S_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              sti_rd   <= 1'b0;
              sti_addr <= '0;
              res_wr   <= 1'b0;
              res_addr <= '0;
              res_do   <= '0;
            end else begin
              // Prefetched word is on the bus now: same unpack as FETCH.
              w_cnt    <= w_cnt + 10'd1;
              k_cnt    <= '0;
              sti_rd   <= 1'b0;
              pix_sr   <= {sti_di[14:0], 1'b0};
              res_addr <= {w_cnt + 10'd1, 4'd0};
              res_do   <= {7'b0, sti_di[15]};
              res_wr   <= pix_wr_en(sti_di[15]);
            end
          end else begin
            k_cnt    <= k_cnt + 4'd1;
            pix_sr   <= {pix_sr[14:0], 1'b0};
            res_addr <= {w_cnt, k_cnt + 4'd1};
            res_do   <= {7'b0, pix_sr[15]};
            res_wr   <= pix_wr_en(pix_sr[15]);
            // Request the next word alongside pixel 15 so it is captured on
            // the following edge without a gap.
            if (k_cnt == 4'd14 && w_cnt != LAST_W) begin
              sti_rd   <= 1'b1;
              sti_addr <= w_cnt + 10'd1;
            end else begin
              sti_rd   <= 1'b0;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dt_sti_loader.sv
module tb_dt_sti_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default parameters (write every pixel)
  logic        start_a = 1'b0;
  logic        busy_a, done_a, sti_rd_a, res_wr_a;
  logic [9:0]  sti_addr_a;
  logic [15:0] sti_di_a;
  logic [13:0] res_addr_a;
  logic [7:0]  res_do_a;

  // DUT B: SKIP_ZERO=1
  logic        start_b = 1'b0;
  logic        busy_b, done_b, sti_rd_b, res_wr_b;
  logic [9:0]  sti_addr_b;
  logic [15:0] sti_di_b;
  logic [13:0] res_addr_b;
  logic [7:0]  res_do_b;

  dt_sti_loader dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .sti_rd(sti_rd_a), .sti_addr(sti_addr_a), .sti_di(sti_di_a),
    .res_wr(res_wr_a), .res_addr(res_addr_a), .res_do(res_do_a)
  );

  dt_sti_loader #(.N_WORDS(1024), .SKIP_ZERO(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .sti_rd(sti_rd_b), .sti_addr(sti_addr_b), .sti_di(sti_di_b),
    .res_wr(res_wr_b), .res_addr(res_addr_b), .res_do(res_do_b)
  );

  // ROM and RAM models
  logic [15:0] rom_a [1024];
  logic [15:0] rom_b [1024];
  logic [7:0]  res_m [16384];
  logic [7:0]  skip_m [16384];
  logic        clr_a = 1'b0;
  logic        clr_b = 1'b0;

  always @(negedge clk) begin
    if (sti_rd_a) sti_di_a <= rom_a[sti_addr_a];
    if (sti_rd_b) sti_di_b <= rom_b[sti_addr_b];
  end

  always @(posedge clk) begin
    if (clr_a) begin
      for (int i = 0; i < 16384; i++) res_m[i] <= 8'hEE;
    end else if (res_wr_a) begin
      res_m[res_addr_a] <= res_do_a;
    end
  end

  always @(posedge clk) begin
    if (clr_b) begin
      for (int i = 0; i < 16384; i++) skip_m[i] <= 8'h00;
    end else if (res_wr_b) begin
      skip_m[res_addr_b] <= res_do_b;
    end
  end

  // Free-running monitors; tests work on differences of these counters.
  int cyc = 0;
  int wr_cnt_a = 0, done_cnt_a = 0, done_cyc_a = 0, rd_cnt_a = 0;
  int wr_cnt_b = 0, done_cnt_b = 0, bad_b = 0;
  logic [15:0] k_ok = 16'hA5A5;  // bit k set: pixel k of 16'hA5A5 is 1

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (res_wr_a) wr_cnt_a <= wr_cnt_a + 1;
    if (sti_rd_a) rd_cnt_a <= rd_cnt_a + 1;
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      done_cyc_a <= cyc;
    end
    if (res_wr_b) begin
      wr_cnt_b <= wr_cnt_b + 1;
      if (!k_ok[res_addr_b[3:0]] || res_do_b != 8'd1) bad_b <= bad_b + 1;
    end
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done_a(input int base_done, input int limit);
    int n = 0;
    while (done_cnt_a == base_done && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("done_timeout", 32'(done_cnt_a != base_done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
  endtask

  function automatic int img_mism();
    int n = 0;
    logic [15:0] wd;
    for (int i = 0; i < 16384; i++) begin
      wd = rom_a[i >> 4];
      if (res_m[i] !== {7'b0, wd[15 - (i & 15)]}) n++;
    end
    return n;
  endfunction

  typedef struct {
    logic        start;
    logic        busy;
    logic        done;
    logic        sti_rd;
    logic [9:0]  sti_addr;
    logic        res_wr;
    logic [13:0] res_addr;
    logic [7:0]  res_do;
  } vec_t;

  vec_t vecs [20];

  initial begin
    int t0, base_wr, base_done, base_rd, base_wr_b, base_done_b, base_bad_b, nz, n;

    // Row r: stimulus before edge E(r), expected outputs after it, for
    // word0=FFFF, word1=0000. Row 6 is a start pulse mid-run (ignored).
    for (int r = 0; r < 20; r++) begin
      vecs[r].start    = (r == 0 || r == 6);
      vecs[r].busy     = 1'b1;
      vecs[r].done     = 1'b0;
      vecs[r].sti_rd   = (r == 0 || r == 16);
      vecs[r].sti_addr = (r >= 16) ? 10'd1 : 10'd0;
      vecs[r].res_wr   = (r != 0);
      vecs[r].res_addr = (r == 0) ? 14'd0 : 14'(r - 1);
      vecs[r].res_do   = (r >= 1 && r <= 16) ? 8'd1 : 8'd0;
    end

    for (int i = 0; i < 1024; i++) begin
      rom_a[i] = 16'h0000;
      rom_b[i] = 16'hA5A5;
    end
    rom_a[0] = 16'h8001;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_sti_rd", 32'(sti_rd_a), 0);
    check("rst_res_wr", 32'(res_wr_a), 0);
    check("rst_sti_addr", 32'(sti_addr_a), 0);
    check("rst_res_addr", 32'(res_addr_a), 0);
    check("rst_res_do", 32'(res_do_a), 0);
    rst = 1'b0;
    base_rd = rd_cnt_a;
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (busy_a || done_a || sti_rd_a || res_wr_a || sti_addr_a != 0 ||
          res_addr_a != 0 || res_do_a != 0) nz++;
    end
    check("idle_outputs_nonzero", 32'(nz), 0);
    check("idle_rom_reads", 32'(rd_cnt_a - base_rd), 0);

    // Single-word pattern on A, SKIP_ZERO on B, run side by side
    clear_a();
    clr_b = 1'b1;
    @(posedge clk);
    #1;
    clr_b = 1'b0;
    base_wr = wr_cnt_a; base_done = done_cnt_a;
    base_wr_b = wr_cnt_b; base_done_b = done_cnt_b; base_bad_b = bad_b;
    start_a = 1'b1; start_b = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start_a = 1'b0; start_b = 1'b0;
    wait_done_a(base_done, 17000);
    check("sw_m0", 32'(res_m[0]), 1);
    check("sw_m15", 32'(res_m[15]), 1);
    n = 0;
    for (int i = 1; i < 15; i++) if (res_m[i] !== 8'd0) n++;
    for (int i = 16; i < 16384; i++) if (res_m[i] !== 8'd0) n++;
    check("sw_other_bytes_nonzero", 32'(n), 0);
    check("sw_write_count", 32'(wr_cnt_a - base_wr), 16384);
    check("sw_done_cycles", 32'(done_cnt_a - base_done), 1);
    check("sw_done_edge", 32'(done_cyc_a - t0), 16385);
    check("skip_write_count", 32'(wr_cnt_b - base_wr_b), 8192);
    check("skip_bad_writes", 32'(bad_b - base_bad_b), 0);
    check("skip_done_cycles", 32'(done_cnt_b - base_done_b), 1);
    n = 0;
    for (int i = 0; i < 16384; i++) if (skip_m[i] !== {7'b0, k_ok[i & 15]}) n++;
    check("skip_image_mism", 32'(n), 0);

    // Prefetch continuity and full image
    rom_a[0] = 16'hFFFF;
    rom_a[1] = 16'h0000;
    for (int i = 2; i < 1024; i++) rom_a[i] = 16'((i * 32'h9E37) ^ 32'h5A3C);
    clear_a();
    base_wr = wr_cnt_a; base_done = done_cnt_a;
    for (int r = 0; r < 20; r++) begin
      start_a = vecs[r].start;
      @(posedge clk);
      #1;
      if (r == 0) t0 = cyc;
      check($sformatf("vec%0d_busy", r), 32'(busy_a), 32'(vecs[r].busy));
      check($sformatf("vec%0d_done", r), 32'(done_a), 32'(vecs[r].done));
      check($sformatf("vec%0d_sti_rd", r), 32'(sti_rd_a), 32'(vecs[r].sti_rd));
      check($sformatf("vec%0d_sti_addr", r), 32'(sti_addr_a), 32'(vecs[r].sti_addr));
      check($sformatf("vec%0d_res_wr", r), 32'(res_wr_a), 32'(vecs[r].res_wr));
      check($sformatf("vec%0d_res_addr", r), 32'(res_addr_a), 32'(vecs[r].res_addr));
      check($sformatf("vec%0d_res_do", r), 32'(res_do_a), 32'(vecs[r].res_do));
    end
    start_a = 1'b0;
    wait_done_a(base_done, 17000);
    check("img_m16", 32'(res_m[16]), 0);
    check("img_mism", 32'(img_mism()), 0);
    check("img_write_count", 32'(wr_cnt_a - base_wr), 16384);
    check("img_done_cycles", 32'(done_cnt_a - base_done), 1);
    check("img_done_edge", 32'(done_cyc_a - t0), 16385);

    // Abort with reset at E100
    clear_a();
    base_wr = wr_cnt_a; base_done = done_cnt_a;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy_a), 0);
    check("abort_res_wr", 32'(res_wr_a), 0);
    check("abort_sti_rd", 32'(sti_rd_a), 0);
    check("abort_writes_before", 32'(wr_cnt_a - base_wr), 99);
    base_wr = wr_cnt_a;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_writes_after", 32'(wr_cnt_a - base_wr), 0);
    check("abort_no_done", 32'(done_cnt_a - base_done), 0);
    check("abort_idle_busy", 32'(busy_a), 0);

    // Restart, with an ignored second start pulse mid-run
    clear_a();
    base_wr = wr_cnt_a; base_done = done_cnt_a;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start_a = 1'b0;
    @(posedge clk);
    #1;
    check("restart_res_addr", 32'(res_addr_a), 0);
    check("restart_res_wr", 32'(res_wr_a), 1);
    check("restart_res_do", 32'(res_do_a), 1);
    repeat (400) @(posedge clk);
    #1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    wait_done_a(base_done, 17000);
    check("restart_mism", 32'(img_mism()), 0);
    check("restart_write_count", 32'(wr_cnt_a - base_wr), 16384);
    check("restart_done_cycles", 32'(done_cnt_a - base_done), 1);
    check("restart_done_edge", 32'(done_cyc_a - t0), 16385);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
